// File: rtl/ps2_defs.sv
// Shared definitions for the PS/2 device-side engine.
// State encodings, frame sizes and the odd-parity helper.
package ps2_defs;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TX,
        ST_GAP,
        ST_INHIBIT,
        ST_RX_REQ,
        ST_RX,
        ST_RX_ACK
    } ps2_state_e;

    localparam int FRAME_BITS = 11;
    localparam int RX_BITS    = 10;
    // Pad inputs are seen this many cycles after the device changes its own drive.
    localparam int SYNC_LAT   = 2;

    // Odd parity: parity bit that makes the count of ones in data+parity odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~(^d);
    endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// Small synchronous byte FIFO holding bytes queued for transmission.
// Push is ignored while full, pop is ignored while empty.
module ps2_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [7:0] din_i,
    output logic [7:0] head_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_q];

    // Storage array, written on accepted pushes only.
    always_ff @(posedge clk_in) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/ps2_device_model.sv
// PS/2 device-side engine: generates the clock, sends queued bytes,
// honours host inhibit and receives host commands with ACK.
module ps2_device_model
    import ps2_defs::*;
#(
    parameter int CLK_HALF    = 1000,
    parameter int FIFO_DEPTH  = 4,
    parameter int INHIBIT_MIN = 50,
    parameter int GAP_HALVES  = 2
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       inject_parity_err,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       inhibited
);

    localparam int GAP_CYC = GAP_HALVES * CLK_HALF;
    localparam int CW      = $clog2(GAP_CYC + CLK_HALF + 1);
    localparam int IW      = $clog2(INHIBIT_MIN + 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLK_HALF - 1);
    localparam logic [CW-1:0] GAP_END  = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] SYNC_CW  = CW'(SYNC_LAT);
    localparam logic [IW-1:0] INH_MAX  = IW'(INHIBIT_MIN);

    ps2_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    bit_q;
    logic [9:0]    frame_q;
    logic [9:0]    rx_sh_q;
    logic [IW-1:0] inh_q;
    logic          clk_m_q, clk_s_q, dat_m_q, dat_s_q;
    logic          clk_oe_q, data_oe_q, inhibited_q, pop_q;
    logic          rx_valid_q, rx_err_q;
    logic [7:0]    rx_data_q;
    logic [7:0]    head;
    logic          fifo_full, fifo_empty;
    logic          inh_det, adv, slot_end;

    ps2_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .push_i  (tx_valid),
        .pop_i   (pop_q),
        .din_i   (tx_data),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign tx_ready    = !fifo_full;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign busy        = (state_q != ST_IDLE);
    assign inhibited   = inhibited_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign rx_err      = rx_err_q;
    assign inh_det     = (inh_q == INH_MAX);

    // A released clock that the host still holds low stalls the high phase
    // (after the synchroniser has caught up with our own release), so a host
    // inhibit accumulates as consecutive low cycles.
    assign adv      = clk_oe_q || (cnt_q < SYNC_CW) || clk_s_q;
    assign slot_end = adv && (cnt_q == HALF_END);

    // Two-flop synchronisers for both pad levels, idle-high at reset.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            clk_m_q <= 1'b1;
            clk_s_q <= 1'b1;
            dat_m_q <= 1'b1;
            dat_s_q <= 1'b1;
        end else begin
            clk_m_q <= ps2_clk_in;
            clk_s_q <= clk_m_q;
            dat_m_q <= ps2_data_in;
            dat_s_q <= dat_m_q;
        end
    end

    // Consecutive clock-low cycles not caused by our own drive.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            inh_q <= '0;
        end else if (clk_s_q || clk_oe_q) begin
            inh_q <= '0;
        end else if (!inh_det) begin
            inh_q <= inh_q + 1'b1;
        end
    end

    // Main protocol FSM with registered pad drives and status outputs.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            frame_q     <= '0;
            rx_sh_q     <= '0;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
            inhibited_q <= 1'b0;
            pop_q       <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_err_q    <= 1'b0;
            rx_data_q   <= '0;
        end else begin
            pop_q      <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
            if (inh_det && state_q != ST_INHIBIT) begin
                state_q     <= ST_INHIBIT;
                inhibited_q <= 1'b1;
                clk_oe_q    <= 1'b0;
                data_oe_q   <= 1'b0;
                cnt_q       <= '0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        cnt_q <= '0;
                        bit_q <= '0;
                        if (clk_s_q && !dat_s_q) begin
                            state_q <= ST_RX_REQ;
                        end else if (!fifo_empty && clk_s_q && dat_s_q) begin
                            state_q   <= ST_TX;
                            frame_q   <= {1'b1,
                                          odd_parity(head) ^ inject_parity_err,
                                          head};
                            data_oe_q <= 1'b1;
                        end
                    end
                    ST_TX: begin
                        if (adv) cnt_q <= slot_end ? '0 : cnt_q + 1'b1;
                        if (slot_end && !clk_oe_q) begin
                            clk_oe_q <= 1'b1;
                        end else if (slot_end) begin
                            clk_oe_q <= 1'b0;
                            if (bit_q == 4'(FRAME_BITS - 1)) begin
                                state_q   <= ST_GAP;
                                data_oe_q <= 1'b0;
                                pop_q     <= 1'b1;
                            end else begin
                                bit_q     <= bit_q + 1'b1;
                                data_oe_q <= ~frame_q[0];
                                frame_q   <= frame_q >> 1;
                            end
                        end
                    end
                    ST_GAP: begin
                        if (cnt_q == GAP_END) begin
                            state_q <= ST_IDLE;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    ST_INHIBIT: begin
                        clk_oe_q  <= 1'b0;
                        data_oe_q <= 1'b0;
                        cnt_q     <= '0;
                        if (clk_s_q) begin
                            inhibited_q <= 1'b0;
                            state_q     <= dat_s_q ? ST_IDLE : ST_RX_REQ;
                        end
                    end
                    ST_RX_REQ: begin
                        if (cnt_q == HALF_END) begin
                            state_q  <= ST_RX;
                            cnt_q    <= '0;
                            bit_q    <= '0;
                            clk_oe_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    ST_RX: begin
                        // Host moves data while clock is low; sample at end of high.
                        if (adv) cnt_q <= slot_end ? '0 : cnt_q + 1'b1;
                        if (slot_end && clk_oe_q) begin
                            clk_oe_q <= 1'b0;
                        end else if (slot_end) begin
                            rx_sh_q  <= {dat_s_q, rx_sh_q[9:1]};
                            clk_oe_q <= 1'b1;
                            if (bit_q == 4'(RX_BITS - 1)) begin
                                state_q   <= ST_RX_ACK;
                                data_oe_q <= dat_s_q;
                                bit_q     <= '0;
                            end else begin
                                bit_q <= bit_q + 1'b1;
                            end
                        end
                    end
                    ST_RX_ACK: begin
                        if (adv) cnt_q <= slot_end ? '0 : cnt_q + 1'b1;
                        if (slot_end && clk_oe_q) begin
                            clk_oe_q <= 1'b0;
                        end else if (slot_end) begin
                            state_q    <= ST_GAP;
                            data_oe_q  <= 1'b0;
                            rx_valid_q <= 1'b1;
                            rx_data_q  <= rx_sh_q[7:0];
                            rx_err_q   <= (odd_parity(rx_sh_q[7:0]) != rx_sh_q[8])
                                          || !rx_sh_q[9];
                        end
                    end
                    default: begin
                        state_q   <= ST_IDLE;
                        clk_oe_q  <= 1'b0;
                        data_oe_q <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_device_model.sv
// Directed bench for ps2_device_model with an open-drain bus model
// and a host that samples device frames and sends commands.
module tb_ps2_device_model;

    localparam int CH = 4;
    localparam int FD = 4;
    localparam int IM = 50;
    localparam int GH = 2;

    logic       clk_in = 1'b0;
    logic       rst_n  = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       inject_parity_err = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, rx_err;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       busy, inhibited;
    logic       host_clk_low  = 1'b0;
    logic       host_data_low = 1'b0;

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic [7:0]  d;
        logic        inj;
        logic [10:0] frame;
    } tx_vec_t;

    typedef struct {
        logic [7:0] d;
        logic       par;
        logic       stop;
        logic       ack;
        logic       err;
    } rx_vec_t;

    tx_vec_t txv[4];
    rx_vec_t rxv[4];
    logic [10:0] fifo_exp[4];

    always #5 clk_in = ~clk_in;

    assign ps2_clk_in  = ~(ps2_clk_oe | host_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | host_data_low);

    ps2_device_model #(
        .CLK_HALF(CH), .FIFO_DEPTH(FD), .INHIBIT_MIN(IM), .GAP_HALVES(GH)
    ) dut (
        .clk_in(clk_in), .rst_n(rst_n),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .inject_parity_err(inject_parity_err),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
        .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
        .busy(busy), .inhibited(inhibited)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Host view: line level at each device-driven falling edge.
    task automatic cap_frame(input int need, output logic [10:0] bits, output int n);
        logic prev;
        prev = ps2_clk_oe;
        bits = '0;
        n = 0;
        for (int c = 0; c < 400 && n < need; c++) begin
            @(negedge clk_in);
            if (ps2_clk_oe && !prev) begin
                bits[n] = ps2_data_in;
                n++;
            end
            prev = ps2_clk_oe;
        end
    endtask

    task automatic push(input logic [7:0] b);
        @(negedge clk_in);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk_in);
        tx_valid = 1'b0;
    endtask

    // Wait for idle, then require no further frame to start.
    task automatic expect_quiet(input string nm);
        logic bad;
        bad = 1'b0;
        for (int k = 0; k < 200 && busy; k++) @(negedge clk_in);
        if (busy) bad = 1'b1;
        repeat (30) begin
            @(negedge clk_in);
            if (ps2_clk_oe) bad = 1'b1;
        end
        chk(nm, 32'(bad), 32'd0);
    endtask

    // Request-to-send, then clock out D0..D7, parity, stop on device clocks.
    task automatic host_send(input logic [7:0] d, input logic par, input logic stop,
                             output logic ack, output int nval,
                             output logic [7:0] rd, output logic re);
        logic [9:0] bits;
        logic prev;
        int n;
        bits = {stop, par, d};
        ack = 1'b0; nval = 0; rd = '0; re = 1'b0; n = 0;
        host_clk_low = 1'b1;
        repeat (IM + 10) @(negedge clk_in);
        host_data_low = 1'b1;
        repeat (2) @(negedge clk_in);
        host_clk_low = 1'b0;
        prev = ps2_clk_oe;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk_in);
            if (ps2_clk_oe && !prev) begin
                if (n < 10) host_data_low = ~bits[n];
                else begin
                    host_data_low = 1'b0;
                    ack = ps2_data_oe;
                end
                n++;
            end
            prev = ps2_clk_oe;
            if (rx_valid) begin
                nval++;
                rd = rx_data;
                re = rx_err;
            end
            if (n >= 11 && !busy) break;
        end
        host_data_low = 1'b0;
    endtask

    initial begin
        logic [10:0] bits;
        int          n;
        logic        ack, re;
        int          nval;
        logic [7:0]  rd;
        logic        rdy3, rdy4;

        txv[0] = '{d: 8'hFA, inj: 1'b0, frame: 11'h7F4};
        txv[1] = '{d: 8'h00, inj: 1'b1, frame: 11'h400};
        txv[2] = '{d: 8'h00, inj: 1'b0, frame: 11'h600};
        txv[3] = '{d: 8'hAA, inj: 1'b0, frame: 11'h754};

        rxv[0] = '{d: 8'hFF, par: 1'b1, stop: 1'b1, ack: 1'b1, err: 1'b0};
        rxv[1] = '{d: 8'hF4, par: 1'b1, stop: 1'b1, ack: 1'b1, err: 1'b1};
        rxv[2] = '{d: 8'hF4, par: 1'b0, stop: 1'b0, ack: 1'b0, err: 1'b1};
        rxv[3] = '{d: 8'hF4, par: 1'b0, stop: 1'b1, ack: 1'b1, err: 1'b0};

        fifo_exp[0] = 11'h622;
        fifo_exp[1] = 11'h644;
        fifo_exp[2] = 11'h666;
        fifo_exp[3] = 11'h688;

        repeat (3) @(negedge clk_in);
        chk("rst_tx_ready",  32'(tx_ready),    32'd1);
        chk("rst_clk_oe",    32'(ps2_clk_oe),  32'd0);
        chk("rst_data_oe",   32'(ps2_data_oe), 32'd0);
        chk("rst_busy",      32'(busy),        32'd0);
        chk("rst_inhibited", 32'(inhibited),   32'd0);
        chk("rst_rx_valid",  32'(rx_valid),    32'd0);
        chk("rst_rx_err",    32'(rx_err),      32'd0);
        chk("rst_rx_data",   32'(rx_data),     32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk_in);

        for (int i = 0; i < 4; i++) begin
            inject_parity_err = txv[i].inj;
            push(txv[i].d);
            cap_frame(11, bits, n);
            inject_parity_err = 1'b0;
            chk($sformatf("tx%0d_edges", i), 32'(n), 32'd11);
            chk($sformatf("tx%0d_frame", i), 32'(bits), 32'(txv[i].frame));
            expect_quiet($sformatf("tx%0d_fifo_empty", i));
        end

        // Inhibit after the 4th falling edge aborts; head is resent in full.
        push(8'h08);
        push(8'h01);
        cap_frame(4, bits, n);
        host_clk_low = 1'b1;
        chk("abort_edges", 32'(n), 32'd4);
        repeat (IM + 10) @(negedge clk_in);
        chk("inh_set",     32'(inhibited),   32'd1);
        chk("inh_clk_rel", 32'(ps2_clk_oe),  32'd0);
        chk("inh_dat_rel", 32'(ps2_data_oe), 32'd0);
        host_clk_low = 1'b0;
        repeat (4) @(negedge clk_in);
        chk("inh_clear", 32'(inhibited), 32'd0);
        cap_frame(11, bits, n);
        chk("resend_08", 32'(bits), 32'h410);
        cap_frame(11, bits, n);
        chk("next_01", 32'(bits), 32'h402);
        expect_quiet("abort_fifo_empty");

        for (int i = 0; i < 4; i++) begin
            host_send(rxv[i].d, rxv[i].par, rxv[i].stop, ack, nval, rd, re);
            chk($sformatf("rx%0d_ack", i),   32'(ack),  32'(rxv[i].ack));
            chk($sformatf("rx%0d_valid", i), 32'(nval), 32'd1);
            chk($sformatf("rx%0d_data", i),  32'(rd),   32'(rxv[i].d));
            chk($sformatf("rx%0d_err", i),   32'(re),   32'(rxv[i].err));
            repeat (10) @(negedge clk_in);
        end

        // Back-to-back pushes past the FIFO depth; the fifth is dropped.
        rdy3 = 1'b0;
        rdy4 = 1'b1;
        for (int k = 0; k <= FD; k++) begin
            @(negedge clk_in);
            if (k == FD - 1) rdy3 = tx_ready;
            if (k == FD) rdy4 = tx_ready;
            tx_data  = 8'h11 * 8'(k + 1);
            tx_valid = 1'b1;
        end
        @(negedge clk_in);
        tx_valid = 1'b0;
        chk("full_ready_before_4th", 32'(rdy3), 32'd1);
        chk("full_ready_after_4th",  32'(rdy4), 32'd0);
        for (int k = 0; k < FD; k++) begin
            cap_frame(11, bits, n);
            chk($sformatf("fifo%0d_frame", k), 32'(bits), 32'(fifo_exp[k]));
        end
        expect_quiet("fifth_dropped");

        // Asynchronous reset mid-frame releases the bus at once.
        push(8'h77);
        for (int c = 0; c < 100 && !ps2_clk_oe; c++) @(negedge clk_in);
        chk("midframe_reached", 32'(ps2_clk_oe), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_clk_oe",   32'(ps2_clk_oe),  32'd0);
        chk("arst_data_oe",  32'(ps2_data_oe), 32'd0);
        chk("arst_tx_ready", 32'(tx_ready),    32'd1);
        chk("arst_busy",     32'(busy),        32'd0);
        repeat (2) @(negedge clk_in);
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
